fd_pipe_reg: RTL and testbench
==============================

FD_PIPE_REG -- requirements
Module: fd_pipe_reg

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 32'h0000_3000, giving the PC value at reset and in bubbles.
REQ-002 The block SHALL have parameter EXC_ENTRY, default 32'h0000_4180, giving the handler PC loaded on Req.
REQ-003 The block SHALL have parameter IM_LO, default 32'h0000_3000, giving the lowest legal fetch address.
REQ-004 The block SHALL have parameter IM_HI, default 32'h0000_6FFC, giving the highest legal fetch address.
REQ-005 The block SHALL have parameter HANG_LIMIT, default 16'd1000, giving the consecutive-stall count that raises Hang.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port F_PC, input, 32 bits: PC of the fetched instruction.
REQ-009 The block SHALL have port F_Instr, input, 32 bits: instruction word read from IM.
REQ-010 The block SHALL have port F_BD, input, 1 bit: the fetched instruction is in a branch delay slot.
REQ-011 The block SHALL have port Stall, input, 1 bit: hold the D stage (from hazard unit).
REQ-012 The block SHALL have port Flush, input, 1 bit: replace the D stage with a bubble (delay-slot kill).
REQ-013 The block SHALL have port Req, input, 1 bit: exception/interrupt taken; flush the D stage to the handler.
REQ-014 The block SHALL have outputs D_PC (32 bits), D_Instr (32 bits), D_ExcCode (5 bits), D_BD (1 bit), D_Valid (1 bit), StallCnt (16 bits) and Hang (1 bit), all registered.

Function
REQ-015 F_PC SHALL be flagged fetch-illegal when F_PC[1:0]!=2'b00, F_PC<IM_LO, or F_PC>IM_HI (unsigned compare).
REQ-016 Normal load (no RESET, no Req, no Stall, no Flush) SHALL register D_PC=F_PC, D_BD=F_BD and D_Valid=1.
REQ-017 On a normal load of a fetch-illegal PC, D_Instr SHALL be 0 and D_ExcCode SHALL be 5'd4 (AdEL).
REQ-018 On a normal load of a legal PC, D_Instr SHALL be F_Instr and D_ExcCode SHALL be 0.
REQ-019 Priority SHALL be RESET > Req > Stall > Flush > normal load, evaluated every cycle.
REQ-020 Req SHALL load D_PC=EXC_ENTRY, D_Instr=0, D_ExcCode=0, D_BD=0 and D_Valid=0, overriding a simultaneous Stall.
REQ-021 Stall, when it is the winning condition, SHALL hold all D_* outputs unchanged; a simultaneous Flush is ignored (the kill is re-asserted by the hazard logic after the stall).
REQ-022 Flush, when it is the winning condition, SHALL load D_PC=F_PC, D_Instr=0, D_ExcCode=0, D_BD=0 and D_Valid=0 (a bubble that keeps the PC for EPC tracing).
REQ-023 StallCnt SHALL increment by 1 each cycle in which Stall=1 and Req=0, and SHALL saturate at 16'hFFFF without wrapping.
REQ-024 StallCnt SHALL clear to 0 on any cycle with Stall=0 or Req=1.
REQ-025 Hang SHALL be registered, set on the edge at which StallCnt becomes >= HANG_LIMIT, and remain set until StallCnt clears.
REQ-026 D_Instr SHALL be 0 whenever D_Valid=0, and a NOP SHALL be 32'h0000_0000.
REQ-027 Outputs SHALL depend only on registered state, with no combinational input-to-output path.

Reset
REQ-028 On RESET=1 at a rising edge, D_PC SHALL be PC_RESET, and D_Instr, D_ExcCode, D_BD, D_Valid, StallCnt and Hang SHALL all be 0.
REQ-029 RESET SHALL override Req, Stall and Flush in the same cycle, including mid-stall, where StallCnt returns to 0 and Hang drops.
REQ-030 Before the first RESET, registers SHALL be initialised to their reset values for simulation.

Verification
REQ-031 The bench SHALL cover: RESET, then F_PC=0x3000, F_Instr=0x3C01_1234, F_BD=0 with no controls -> next edge D_PC=0x3000, D_Instr=0x3C01_1234, D_Valid=1, D_ExcCode=0.
REQ-032 The bench SHALL cover: F_PC=0x3002, then F_PC=0x2FFC, then F_PC=0x7000 -> each load gives D_ExcCode=4 and D_Instr=0; F_PC=0x6FFC loads cleanly.
REQ-033 The bench SHALL cover: Stall=1 for 3 cycles while F_PC changes -> D_* hold their values and StallCnt reads 1, 2, 3; on Stall=0 the next load occurs and StallCnt=0.
REQ-034 The bench SHALL cover: Stall=1 and Req=1 together -> D_PC=0x4180, D_Valid=0, StallCnt=0; Stall=1 and Flush=1 together -> hold.
REQ-035 The bench SHALL cover: Flush=1 with F_PC=0x3010, F_BD=1 -> D_PC=0x3010, D_Instr=0, D_BD=0, D_Valid=0.
REQ-036 The bench SHALL cover: with HANG_LIMIT=4, Stall held 6 cycles -> Hang=1 from the 4th edge; then RESET -> Hang=0, StallCnt=0, D_PC=0x3000.

Source files
------------

// File: rtl/fd_pipe_reg.sv
// ---------------------------------------------------------------------------
// fd_pipe_reg
//
// Fetch/decode pipeline register. It captures the instruction fetched in the
// F stage into the D stage. It also checks the fetch address for alignment
// and range, and marks illegal fetches with an AdEL exception code. It
// supports hazard stalls, delay-slot kills (bubbles) and redirection to the
// exception handler. A consecutive-stall counter raises Hang when the
// pipeline has been frozen for too long.
//
// Parameters
//   PC_RESET   : PC held in D after reset
//   EXC_ENTRY  : handler PC loaded when an exception/interrupt is taken
//   IM_LO/IM_HI: inclusive legal fetch address window
//   HANG_LIMIT : consecutive stall cycles that raise Hang
//
// Ports
//   CLK, RESET         : clock, synchronous active-high reset
//   F_PC, F_Instr, F_BD: fetched PC, instruction word, delay-slot flag
//   Stall, Flush, Req  : hold D, bubble D, redirect D to handler
//   D_PC, D_Instr, D_ExcCode, D_BD, D_Valid : registered D-stage contents
//   StallCnt, Hang     : registered stall counter and hang indicator
// ---------------------------------------------------------------------------
module fd_pipe_reg #(
   parameter logic [31:0] PC_RESET   = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
   parameter logic [31:0] IM_LO      = 32'h0000_3000,
   parameter logic [31:0] IM_HI      = 32'h0000_6FFC,
   parameter logic [15:0] HANG_LIMIT = 16'd1000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] F_PC,
   input  logic [31:0] F_Instr,
   input  logic        F_BD,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        Req,
   output logic [31:0] D_PC,
   output logic [31:0] D_Instr,
   output logic [4:0]  D_ExcCode,
   output logic        D_BD,
   output logic        D_Valid,
   output logic [15:0] StallCnt,
   output logic        Hang
);

   localparam logic [4:0] EXC_ADEL = 5'd4;

   // The declaration initialisers give the simulator the reset values before
   // the first RESET pulse arrives.
   logic [31:0] d_pc_q       = PC_RESET;
   logic [31:0] d_instr_q    = 32'h0000_0000;
   logic [4:0]  d_exc_code_q = 5'd0;
   logic        d_bd_q       = 1'b0;
   logic        d_valid_q    = 1'b0;
   logic [15:0] stall_cnt_q  = 16'd0;
   logic        hang_q       = 1'b0;

   logic [31:0] d_pc_d;
   logic [31:0] d_instr_d;
   logic [4:0]  d_exc_code_d;
   logic        d_bd_d;
   logic        d_valid_d;
   logic [15:0] stall_cnt_d;
   logic        hang_d;
   logic        fetch_illegal;

   // A fetch is illegal if the address is misaligned or lies outside the
   // instruction memory window. The window bounds are inclusive.
   always_comb begin
      fetch_illegal = (F_PC[1:0] != 2'b00) || (F_PC < IM_LO) || (F_PC > IM_HI);
   end

   // Next-state logic for the D-stage contents. Req has priority over Stall
   // and Flush. Stall has priority over Flush: the hazard logic re-asserts the
   // kill after the stall clears. A bubble always carries a zero (NOP)
   // instruction word.
   always_comb begin
      d_pc_d       = d_pc_q;
      d_instr_d    = d_instr_q;
      d_exc_code_d = d_exc_code_q;
      d_bd_d       = d_bd_q;
      d_valid_d    = d_valid_q;
      if (Req) begin
         d_pc_d       = EXC_ENTRY;
         d_instr_d    = 32'h0000_0000;
         d_exc_code_d = 5'd0;
         d_bd_d       = 1'b0;
         d_valid_d    = 1'b0;
      end else if (Stall) begin
         d_pc_d       = d_pc_q;
      end else if (Flush) begin
         // The bubble keeps the fetched PC so that EPC tracing still works.
         d_pc_d       = F_PC;
         d_instr_d    = 32'h0000_0000;
         d_exc_code_d = 5'd0;
         d_bd_d       = 1'b0;
         d_valid_d    = 1'b0;
      end else begin
         d_pc_d       = F_PC;
         d_bd_d       = F_BD;
         d_valid_d    = 1'b1;
         if (fetch_illegal) begin
            d_instr_d    = 32'h0000_0000;
            d_exc_code_d = EXC_ADEL;
         end else begin
            d_instr_d    = F_Instr;
            d_exc_code_d = 5'd0;
         end
      end
   end

   // Stall counter. It counts consecutive effective stalls. A Req cancels the
   // stall, so it clears the counter. The counter saturates at its maximum
   // value instead of wrapping. Hang follows the next count value, so it is
   // set on the edge where the limit is reached. It stays set until the
   // counter clears.
   always_comb begin
      stall_cnt_d = 16'd0;
      if (Stall && !Req) begin
         if (stall_cnt_q == 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q;
         end else begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end
      end
      hang_d = (stall_cnt_d >= HANG_LIMIT);
   end

   // State registers. RESET is synchronous and overrides every other control.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         d_pc_q       <= PC_RESET;
         d_instr_q    <= 32'h0000_0000;
         d_exc_code_q <= 5'd0;
         d_bd_q       <= 1'b0;
         d_valid_q    <= 1'b0;
         stall_cnt_q  <= 16'd0;
         hang_q       <= 1'b0;
      end else begin
         d_pc_q       <= d_pc_d;
         d_instr_q    <= d_instr_d;
         d_exc_code_q <= d_exc_code_d;
         d_bd_q       <= d_bd_d;
         d_valid_q    <= d_valid_d;
         stall_cnt_q  <= stall_cnt_d;
         hang_q       <= hang_d;
      end
   end

   // Outputs come straight from flops, so there is no combinational path
   // from any input to any output.
   assign D_PC      = d_pc_q;
   assign D_Instr   = d_instr_q;
   assign D_ExcCode = d_exc_code_q;
   assign D_BD      = d_bd_q;
   assign D_Valid   = d_valid_q;
   assign StallCnt  = stall_cnt_q;
   assign Hang      = hang_q;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_fd_pipe_reg
//
// Directed bench for fd_pipe_reg. The DUT uses HANG_LIMIT=4 so the hang
// indicator is reachable in a few cycles. Each vector drives the inputs on a
// falling edge. It pushes the hand-computed D-stage contents expected after
// the next rising edge into a queue. A monitor pops that entry just after the
// rising edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_fd_pipe_reg;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  exc;
      logic        bd;
      logic        valid;
      logic [15:0] cnt;
      logic        hang;
      string       tag;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] F_PC;
   logic [31:0] F_Instr;
   logic        F_BD;
   logic        Stall;
   logic        Flush;
   logic        Req;
   logic [31:0] D_PC;
   logic [31:0] D_Instr;
   logic [4:0]  D_ExcCode;
   logic        D_BD;
   logic        D_Valid;
   logic [15:0] StallCnt;
   logic        Hang;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   fd_pipe_reg #(
      .PC_RESET  (32'h0000_3000),
      .EXC_ENTRY (32'h0000_4180),
      .IM_LO     (32'h0000_3000),
      .IM_HI     (32'h0000_6FFC),
      .HANG_LIMIT(16'd4)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .F_PC     (F_PC),
      .F_Instr  (F_Instr),
      .F_BD     (F_BD),
      .Stall    (Stall),
      .Flush    (Flush),
      .Req      (Req),
      .D_PC     (D_PC),
      .D_Instr  (D_Instr),
      .D_ExcCode(D_ExcCode),
      .D_BD     (D_BD),
      .D_Valid  (D_Valid),
      .StallCnt (StallCnt),
      .Hang     (Hang)
   );

   // 10 time-unit clock
   always #5 CLK = ~CLK;

   // Compares one output field and updates the scoreboard counters
   task automatic checkField(input string tag, input string name,
                             input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s.%s actual=%h required=%h", tag, name, act, exp);
      end
   endtask

   // Checks every DUT output against one scoreboard entry
   task automatic checkOutput(input exp_t e);
      checkField(e.tag, "D_PC",      D_PC,                e.pc);
      checkField(e.tag, "D_Instr",   D_Instr,             e.instr);
      checkField(e.tag, "D_ExcCode", {27'd0, D_ExcCode},  {27'd0, e.exc});
      checkField(e.tag, "D_BD",      {31'd0, D_BD},       {31'd0, e.bd});
      checkField(e.tag, "D_Valid",   {31'd0, D_Valid},    {31'd0, e.valid});
      checkField(e.tag, "StallCnt",  {16'd0, StallCnt},   {16'd0, e.cnt});
      checkField(e.tag, "Hang",      {31'd0, Hang},       {31'd0, e.hang});
   endtask

   // Drives one vector on the falling edge and queues what D must hold after
   // the following rising edge
   task automatic applyStimulus(input string tag,
                                input logic rst, input logic stl, input logic fls, input logic rq,
                                input logic [31:0] pc, input logic [31:0] instr, input logic bd,
                                input logic [31:0] ePc, input logic [31:0] eInstr, input logic [4:0] eExc,
                                input logic eBd, input logic eValid, input logic [15:0] eCnt,
                                input logic eHang);
      exp_t e;
      @(negedge CLK);
      RESET   = rst;
      Stall   = stl;
      Flush   = fls;
      Req     = rq;
      F_PC    = pc;
      F_Instr = instr;
      F_BD    = bd;
      e.tag   = tag;
      e.pc    = ePc;
      e.instr = eInstr;
      e.exc   = eExc;
      e.bd    = eBd;
      e.valid = eValid;
      e.cnt   = eCnt;
      e.hang  = eHang;
      expQ.push_back(e);
   endtask

   // Monitor: samples just after every rising edge and pops one entry
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed vectors: tag, RESET, Stall, Flush, Req, F_PC, F_Instr, F_BD,
   // then expected D_PC, D_Instr, D_ExcCode, D_BD, D_Valid, StallCnt, Hang
   initial begin
      RESET = 1'b1; Stall = 1'b0; Flush = 1'b0; Req = 1'b0;
      F_PC = 32'h0; F_Instr = 32'h0; F_BD = 1'b0;

      applyStimulus("reset",     1,0,0,0, 32'h0000_3000, 32'h0,          0, 32'h0000_3000, 32'h0,          0, 0, 0, 0, 0);
      applyStimulus("load3000",  0,0,0,0, 32'h0000_3000, 32'h3C01_1234,  0, 32'h0000_3000, 32'h3C01_1234,  0, 0, 1, 0, 0);
      applyStimulus("misalign",  0,0,0,0, 32'h0000_3002, 32'h1111_1111,  0, 32'h0000_3002, 32'h0,          4, 0, 1, 0, 0);
      applyStimulus("belowLo",   0,0,0,0, 32'h0000_2FFC, 32'h2222_2222,  1, 32'h0000_2FFC, 32'h0,          4, 1, 1, 0, 0);
      applyStimulus("aboveHi",   0,0,0,0, 32'h0000_7000, 32'h3333_3333,  0, 32'h0000_7000, 32'h0,          4, 0, 1, 0, 0);
      applyStimulus("atHi",      0,0,0,0, 32'h0000_6FFC, 32'h2442_0005,  0, 32'h0000_6FFC, 32'h2442_0005,  0, 0, 1, 0, 0);
      applyStimulus("stall1",    0,1,0,0, 32'h0000_3100, 32'hAAAA_0001,  1, 32'h0000_6FFC, 32'h2442_0005,  0, 0, 1, 1, 0);
      applyStimulus("stall2",    0,1,0,0, 32'h0000_3104, 32'hAAAA_0002,  0, 32'h0000_6FFC, 32'h2442_0005,  0, 0, 1, 2, 0);
      applyStimulus("stall3",    0,1,0,0, 32'h0000_3108, 32'hAAAA_0003,  1, 32'h0000_6FFC, 32'h2442_0005,  0, 0, 1, 3, 0);
      applyStimulus("unstall",   0,0,0,0, 32'h0000_310C, 32'h0085_1020,  1, 32'h0000_310C, 32'h0085_1020,  0, 1, 1, 0, 0);
      applyStimulus("stallReq",  0,1,0,1, 32'h0000_3200, 32'hBBBB_0000,  1, 32'h0000_4180, 32'h0,          0, 0, 0, 0, 0);
      applyStimulus("stallFls",  0,1,1,0, 32'h0000_3204, 32'h1234_5678,  1, 32'h0000_4180, 32'h0,          0, 0, 0, 1, 0);
      applyStimulus("flush",     0,0,1,0, 32'h0000_3010, 32'h8C01_0000,  1, 32'h0000_3010, 32'h0,          0, 0, 0, 0, 0);
      applyStimulus("flushBad",  0,0,1,0, 32'h0000_3011, 32'h8C01_0000,  0, 32'h0000_3011, 32'h0,          0, 0, 0, 0, 0);
      applyStimulus("load3014",  0,0,0,0, 32'h0000_3014, 32'h0000_000C,  0, 32'h0000_3014, 32'h0000_000C,  0, 0, 1, 0, 0);
      applyStimulus("reqOnly",   0,0,1,1, 32'h0000_3018, 32'h0000_0020,  1, 32'h0000_4180, 32'h0,          0, 0, 0, 0, 0);
      applyStimulus("load301C",  0,0,0,0, 32'h0000_301C, 32'h0000_0021,  1, 32'h0000_301C, 32'h0000_0021,  0, 1, 1, 0, 0);
      applyStimulus("hang1",     0,1,0,0, 32'h0000_3400, 32'hCCCC_0001,  0, 32'h0000_301C, 32'h0000_0021,  0, 1, 1, 1, 0);
      applyStimulus("hang2",     0,1,0,0, 32'h0000_3404, 32'hCCCC_0002,  0, 32'h0000_301C, 32'h0000_0021,  0, 1, 1, 2, 0);
      applyStimulus("hang3",     0,1,0,0, 32'h0000_3408, 32'hCCCC_0003,  0, 32'h0000_301C, 32'h0000_0021,  0, 1, 1, 3, 0);
      applyStimulus("hang4",     0,1,0,0, 32'h0000_340C, 32'hCCCC_0004,  0, 32'h0000_301C, 32'h0000_0021,  0, 1, 1, 4, 1);
      applyStimulus("hang5",     0,1,0,0, 32'h0000_3410, 32'hCCCC_0005,  0, 32'h0000_301C, 32'h0000_0021,  0, 1, 1, 5, 1);
      applyStimulus("hang6",     0,1,0,0, 32'h0000_3414, 32'hCCCC_0006,  0, 32'h0000_301C, 32'h0000_0021,  0, 1, 1, 6, 1);
      applyStimulus("resetStl",  1,1,1,1, 32'h0000_3418, 32'hCCCC_0007,  1, 32'h0000_3000, 32'h0,          0, 0, 0, 0, 0);
      applyStimulus("postRst",   0,0,0,0, 32'h0000_3004, 32'h2008_0001,  0, 32'h0000_3004, 32'h2008_0001,  0, 0, 1, 0, 0);

      // Let the monitor drain the queue, with a bounded wait
      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(negedge CLK);
      end
      if (expQ.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain actual=%0d pending required=0 pending", expQ.size());
      end
      @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
